ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 152 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, start, 8 data bits,
// odd parity, stop/ACK, with a filtered device clock and a frame watchdog.
module ps2_host_tx #(
  parameter int RTS_CYCLES   = 10000,
  parameter int TIMEOUT_DVSR = 20000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_wr_ps2,
  input  logic [7:0] i_din,
  input  logic       i_ps2c,
  input  logic       i_ps2d,
  output logic       o_ps2c_low,
  output logic       o_ps2d_low,
  output logic       o_tx_idle,
  output logic       o_tx_done_tick,
  output logic       o_ack_err,
  output logic       o_time_out
);

  localparam int CW = $clog2(RTS_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_DVSR + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RTS   = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [7:0]    filter_q, filter_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [3:0]    n_q, n_d;
  logic [8:0]    shift_q, shift_d;
  logic          ack_err_q, ack_err_d;
  logic          done_q, done_d;
  logic          to_q, to_d;
  logic          fall;
  logic          busy;

  always_comb begin
    filter_d = {i_ps2c, filter_q[7:1]};
    filt_d   = filt_q;
    if (&filter_d)
      filt_d = 1'b1;
    else if (~|filter_d)
      filt_d = 1'b0;
    fall = filt_q & ~filt_d;
  end

  assign busy = (state_q == S_START) ||
                (state_q == S_DATA) ||
                (state_q == S_STOP);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wdog_d    = wdog_q;
    n_d       = n_q;
    shift_d   = shift_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;
    to_d      = 1'b0;
    if (busy)
      wdog_d = fall ? '0 : wdog_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        wdog_d = '0;
        if (i_wr_ps2) begin
          shift_d   = {~^i_din, i_din};
          cnt_d     = CW'(RTS_CYCLES - 1);
          ack_err_d = 1'b0;
          state_d   = S_RTS;
        end
      end
      S_RTS: begin
        wdog_d = '0;
        if (cnt_q == '0)
          state_d = S_START;
        else
          cnt_d = cnt_q - 1'b1;
      end
      S_START: begin
        if (fall) begin
          n_d     = 4'd8;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_d = {1'b0, shift_q[8:1]};
          if (n_q == '0)
            state_d = S_STOP;
          else
            n_d = n_q - 1'b1;
        end
      end
      S_STOP: begin
        if (fall) begin
          ack_err_d = i_ps2d;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A real edge in the same cycle wins over the watchdog expiring.
    if (busy && !fall && wdog_q == WW'(TIMEOUT_DVSR - 1)) begin
      state_d   = S_IDLE;
      wdog_d    = '0;
      ack_err_d = 1'b1;
      to_d      = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      filter_q  <= '0;
      filt_q    <= 1'b0;
      cnt_q     <= '0;
      wdog_q    <= '0;
      n_q       <= '0;
      shift_q   <= '0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      filter_q  <= filter_d;
      filt_q    <= filt_d;
      cnt_q     <= cnt_d;
      wdog_q    <= wdog_d;
      n_q       <= n_d;
      shift_q   <= shift_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
      to_q      <= to_d;
    end
  end

  assign o_ps2c_low     = (state_q == S_RTS);
  assign o_ps2d_low     = (state_q == S_START) ||
                          ((state_q == S_DATA) && !shift_q[0]);
  assign o_tx_idle      = (state_q == S_IDLE);
  assign o_tx_done_tick = done_q;
  assign o_ack_err      = ack_err_q;
  assign o_time_out     = to_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a device model that clocks
// frames; completions and aborts are checked against a scoreboard queue.
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_wr_ps2;
  logic [7:0] i_din;
  logic       i_ps2c;
  logic       i_ps2d;
  logic       o_ps2c_low;
  logic       o_ps2d_low;
  logic       o_tx_idle;
  logic       o_tx_done_tick;
  logic       o_ack_err;
  logic       o_time_out;

  logic dev_c = 1'b1;
  logic dev_d_low = 1'b0;

  assign i_ps2c = ~o_ps2c_low & dev_c;
  assign i_ps2d = ~o_ps2d_low & ~dev_d_low;

  ps2_host_tx #(
    .RTS_CYCLES  (16),
    .TIMEOUT_DVSR(200)
  ) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_wr_ps2      (i_wr_ps2),
    .i_din         (i_din),
    .i_ps2c        (i_ps2c),
    .i_ps2d        (i_ps2d),
    .o_ps2c_low    (o_ps2c_low),
    .o_ps2d_low    (o_ps2d_low),
    .o_tx_idle     (o_tx_idle),
    .o_tx_done_tick(o_tx_done_tick),
    .o_ack_err     (o_ack_err),
    .o_time_out    (o_time_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_to;
    bit          ack_err;
    logic [10:0] bits;
    logic [10:0] mask;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_low = 0;
  int          cur_rts = 0;
  logic [10:0] cap = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every completion or abort must match the head entry.
  always @(negedge clk) begin
    if (!i_reset && (o_tx_done_tick || o_time_out)) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", {o_tx_done_tick, o_time_out}, 0);
      end else begin
        exp_t e;
        int   dly;
        e = sb.pop_front();
        chk("done_tick", o_tx_done_tick, !e.is_to);
        chk("time_out", o_time_out, e.is_to);
        chk("ack_err", o_ack_err, e.ack_err);
        chk("idle_at_end", o_tx_idle, 1);
        chk("lines_released", {o_ps2c_low, o_ps2d_low}, 0);
        chk("frame_bits", cap & e.mask, e.bits & e.mask);
        if (e.is_to) begin
          dly = cyc - last_low;
          chk("to_delay_ok", (dly >= 200 && dly <= 216), 1);
        end
      end
    end
  end

  // kind: 0 = no outcome expected, 1 = completion, 2 = watchdog abort
  task automatic send(input logic [7:0] din, input bit par, input int edges,
                      input bit ack, input int kind, input bit inject,
                      input int glitch);
    exp_t e;
    if (kind != 0) begin
      e.is_to   = (kind == 2);
      e.ack_err = (kind == 2) ? 1'b1 : !ack;
      e.bits    = {1'b1, par, din, 1'b0};
      e.mask    = (kind == 1) ? 11'h7FF : (11'h7FF >> (11 - edges));
      sb.push_back(e);
    end
    cap = '0;
    i_din = din;
    i_wr_ps2 = 1'b1;
    @(negedge clk);
    i_wr_ps2 = 1'b0;
    chk("accept_ps2c_low", o_ps2c_low, 1);
    chk("accept_not_idle", o_tx_idle, 0);
    chk("accept_ack_clr", o_ack_err, 0);
    cur_rts = 1;
    for (int k = 0; k < 100; k++) begin
      if (inject && cur_rts == 5) begin
        i_din = 8'h55;
        i_wr_ps2 = 1'b1;
      end
      @(negedge clk);
      i_wr_ps2 = 1'b0;
      if (o_ps2c_low) cur_rts++;
      else break;
    end
    chk("rts_len", cur_rts, 16);
    repeat (30) @(negedge clk);
    for (int ed = 0; ed < edges; ed++) begin
      if (ed < 11) cap[ed] = i_ps2d;
      if (ed == 10 && ack) dev_d_low = 1'b1;
      dev_c = 1'b0;
      last_low = cyc;
      repeat (20) @(negedge clk);
      dev_c = 1'b1;
      if (glitch == ed) begin
        repeat (10) @(negedge clk);
        dev_c = 1'b0;
        repeat (5) @(negedge clk);
        dev_c = 1'b1;
        repeat (15) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
      dev_d_low = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400 && sb.size() != 0; k++) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    i_reset = 1'b1;
    i_wr_ps2 = 1'b0;
    i_din = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_idle", o_tx_idle, 1);
    chk("rst_lines", {o_ps2c_low, o_ps2d_low}, 0);
    chk("rst_flags", {o_tx_done_tick, o_ack_err, o_time_out}, 0);
    i_reset = 1'b0;
    repeat (12) @(negedge clk);

    send(8'hED, 1'b1, 11, 1'b1, 1, 1'b0, -1);
    wait_drain();
    send(8'h01, 1'b0, 11, 1'b1, 1, 1'b1, -1);
    wait_drain();
    chk("rts_wr_ignored_idle", o_tx_idle, 1);
    send(8'hFF, 1'b1, 11, 1'b1, 1, 1'b0, -1);
    wait_drain();
    send(8'h00, 1'b1, 11, 1'b0, 1, 1'b0, -1);
    wait_drain();
    chk("noack_err_held", o_ack_err, 1);
    send(8'hF4, 1'b0, 4, 1'b0, 2, 1'b0, -1);
    wait_drain();
    chk("to_err_held", o_ack_err, 1);
    send(8'h3C, 1'b1, 11, 1'b1, 1, 1'b0, 3);
    wait_drain();

    send(8'hA5, 1'b1, 5, 1'b0, 0, 1'b0, -1);
    chk("pre_rst_busy", o_tx_idle, 0);
    i_reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_lines", {o_ps2c_low, o_ps2d_low}, 0);
    chk("mid_rst_idle", o_tx_idle, 1);
    chk("mid_rst_flags", {o_tx_done_tick, o_ack_err, o_time_out}, 0);
    i_reset = 1'b0;
    repeat (12) @(negedge clk);

    send(8'h5A, 1'b1, 11, 1'b1, 1, 1'b0, -1);
    wait_drain();
    chk("final_idle", o_tx_idle, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
